// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and the active-low hex pattern table for the seven-segment driver.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam int unsigned DIGIT_W = 4;

    // Cathode patterns indexed by nibble, bit order {g,f,e,d,c,b,a}, 0 lights a segment.
    localparam seg_t SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: display word and per-digit controls in, scanned anode/cathode drive out.
interface seg7_scan_mux_if;
    import seg7_pkg::*;

    logic [31:0] bcd;
    logic [7:0]  digit_en;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    seg_t        seg;
    logic        dp;

    modport master (output bcd, digit_en, dp_mask, input an, seg, dp);
    modport slave  (input bcd, digit_en, dp_mask, output an, seg, dp);

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scans eight digits one per refresh tick with registered active-low outputs,
// taking a frame snapshot of the display word at digit 0 so a frame never mixes two words.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned N_DIGITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_mux_if.slave    bus_if
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick;
    logic          en;
    logic [3:0]    nib;
    seg_t          dec;

    assign tick = cnt_q == CW'(TICK_DIV - 1);
    assign en   = bus_if.digit_en[idx_q];
    // Digit 0 reads the live word on the same edge that loads the snapshot.
    assign nib  = (idx_q == 3'd0) ? bus_if.bcd[3:0] : snap_q[{idx_q, 2'b00} +: DIGIT_W];

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (dec)
    );

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = !tick ? idx_q : (idx_q == 3'(N_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        snap_d = (tick && idx_q == 3'd0) ? bus_if.bcd : snap_q;
        an_d   = tick ? ~(8'(en) << idx_q) : an_q;
        seg_d  = tick ? (en ? dec : SEG_BLANK) : seg_q;
        dp_d   = tick ? ~(bus_if.dp_mask[idx_q] & en) : dp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus_if.an  = an_q;
    assign bus_if.seg = seg_q;
    assign bus_if.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed and randomized checks of two scanners (TICK_DIV 4 and 2)
// against a slot-arithmetic reference model.
module tb_seg7_scan_mux;

    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] bcd = '0;
    logic [7:0]  den = '0;
    logic [7:0]  dpm = '0;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc [2];
    logic [31:0] frame [2];
    logic [15:0] exp_o [2];

    always #5 clk = ~clk;

    seg7_scan_mux_if ifa ();
    seg7_scan_mux_if ifb ();

    assign ifa.bcd = bcd;
    assign ifa.digit_en = den;
    assign ifa.dp_mask = dpm;
    assign ifb.bcd = bcd;
    assign ifb.digit_en = den;
    assign ifb.dp_mask = dpm;

    seg7_scan_mux #(.TICK_DIV(4), .N_DIGITS(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus_if(ifa));
    seg7_scan_mux #(.TICK_DIV(2), .N_DIGITS(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus_if(ifb));

    function automatic int td(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    // Edge n after release is a slot boundary when n is a multiple of the divider.
    function automatic int slot_k(input int d);
        return ((cyc[d] + 1) / td(d) - 1) % 8;
    endfunction

    function automatic logic [15:0] model(input int k, input logic [31:0] fr);
        logic [7:0] a;
        logic [3:0] nb;
        a = 8'hFF;
        nb = fr[k*4 +: 4];
        if (den[k]) a[k] = 1'b0;
        return {a, den[k] ? PAT[nb] : 7'h7F, ~(den[k] & dpm[k])};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cyc[d] <= 0;
                frame[d] <= '0;
                exp_o[d] <= {8'hFF, 7'h7F, 1'b1};
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                cyc[d] <= cyc[d] + 1;
                if ((cyc[d] + 1) % td(d) == 0) begin
                    if (slot_k(d) == 0) frame[d] <= bcd;
                    exp_o[d] <= model(slot_k(d), (slot_k(d) == 0) ? bcd : frame[d]);
                end
            end
        end
    end

    task automatic eq(input string tag, input logic [31:0] o, input logic [31:0] e);
        compared++;
        assert (o === e) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk();
        eq("model_an_a", 32'(ifa.an), 32'(exp_o[0][15:8]));
        eq("model_seg_a", 32'(ifa.seg), 32'(exp_o[0][7:1]));
        eq("model_dp_a", 32'(ifa.dp), 32'(exp_o[0][0]));
        eq("model_an_b", 32'(ifb.an), 32'(exp_o[1][15:8]));
        eq("model_seg_b", 32'(ifb.seg), 32'(exp_o[1][7:1]));
        eq("model_dp_b", 32'(ifb.dp), 32'(exp_o[1][0]));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            chk();
        end
    endtask

    task automatic period(input int d, input int expv);
        logic [7:0] prev;
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            prev = d ? ifb.an : ifa.an;
            n = 0;
            while ((d ? ifb.an : ifa.an) === prev && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        eq(d ? "period_b" : "period_a", 32'(n), 32'(expv));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        bcd = 32'h12345678;
        den = 8'hFF;
        dpm = 8'h00;
        repeat (2) @(negedge clk);
        eq("reset_an", 32'(ifa.an), 32'hFF);
        eq("reset_seg", 32'(ifa.seg), 32'h7F);
        eq("reset_dp", 32'(ifa.dp), 32'h1);
        chk();
        rst_n = 1'b1;
        cycles(3);
        eq("pre_tick_an", 32'(ifa.an), 32'hFF);
        cycles(1);
        eq("first_an", 32'(ifa.an), 32'hFE);
        eq("first_seg", 32'(ifa.seg), 32'(7'b0000000));
        cycles(4);
        eq("slot1_an", 32'(ifa.an), 32'hFD);
        eq("slot1_seg", 32'(ifa.seg), 32'(7'b1111000));
        cycles(24);
        eq("slot7_an", 32'(ifa.an), 32'h7F);
        eq("slot7_seg", 32'(ifa.seg), 32'(7'b1111001));
        cycles(4);
        eq("wrap_an", 32'(ifa.an), 32'hFE);
        cycles(8);
        bcd = 32'hFFFFFFFF;
        cycles(4);
        eq("tear_slot3", 32'(ifa.seg), 32'(7'b0010010));
        cycles(16);
        eq("tear_slot7", 32'(ifa.seg), 32'(7'b1111001));
        cycles(4);
        eq("tear_new_frame", 32'(ifa.seg), 32'(7'b0001110));
        cycles(28);
        eq("tear_frame_end", 32'(ifa.seg), 32'(7'b0001110));
        bcd = 32'h76543210;
        cycles(32);
        bcd = 32'hFEDCBA98;
        cycles(32);
        den = 8'h0F;
        dpm = 8'h02;
        cycles(32);
        cycles(8);
        eq("dp_slot1", 32'(ifa.dp), 32'h0);
        eq("dp_slot1_an", 32'(ifa.an), 32'hFD);
        cycles(8);
        den = 8'hFF;
        dpm = 8'hFF;
        cycles(4);
        eq("slot4_lit", 32'(ifa.an), 32'hEF);
        cycles(2);
        #2 rst_n = 1'b0;
        #1;
        eq("midreset_an", 32'(ifa.an), 32'hFF);
        eq("midreset_seg", 32'(ifa.seg), 32'h7F);
        eq("midreset_dp", 32'(ifa.dp), 32'h1);
        chk();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        eq("restart_hold", 32'(ifa.an), 32'hFF);
        cycles(1);
        eq("restart_an", 32'(ifa.an), 32'hFE);
        eq("restart_seg", 32'(ifa.seg), 32'(7'b0000000));
        period(0, 4);
        period(1, 2);
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) bcd = $urandom;
            if ($urandom_range(0, 15) == 0) den = 8'($urandom);
            if ($urandom_range(0, 15) == 0) dpm = 8'($urandom);
            @(negedge clk);
            chk();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
